// File: rtl/o2_stim_gen_if.sv
// Control/status bundle between a bench controller (master) and o2_stim_gen (slave).
// fault_mask is present only when O2_FAULT_INJ_EN is defined.
interface o2_stim_gen_if #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 24
);
    logic                en;
    logic [1:0]          mode;
    logic                start;
    logic [1:0]          force_state;
    logic [CNT_W-1:0]    normal_len;
    logic [CNT_W-1:0]    lean_len;
    logic [CNT_W-1:0]    rich_len;
    logic [CHANNELS-1:0] o2_top;
    logic [CHANNELS-1:0] o2_bottom;
    logic [CHANNELS-1:0] cycle_done;
    logic                seq_done;
    logic                busy;
`ifdef O2_FAULT_INJ_EN
    logic [CHANNELS-1:0] fault_mask;

    modport master (
        output en, mode, start, force_state, normal_len, lean_len, rich_len, fault_mask,
        input  o2_top, o2_bottom, cycle_done, seq_done, busy
    );

    modport slave (
        input  en, mode, start, force_state, normal_len, lean_len, rich_len, fault_mask,
        output o2_top, o2_bottom, cycle_done, seq_done, busy
    );
`else
    modport master (
        output en, mode, start, force_state, normal_len, lean_len, rich_len,
        input  o2_top, o2_bottom, cycle_done, seq_done, busy
    );

    modport slave (
        input  en, mode, start, force_state, normal_len, lean_len, rich_len,
        output o2_top, o2_bottom, cycle_done, seq_done, busy
    );
`endif
endinterface

// File: rtl/o2_stim_gen.sv
// Multi-channel narrowband O2 sensor stimulus generator cycling NORMAL -> LEAN -> RICH.
// Optional open-circuit fault injection is enabled by defining O2_FAULT_INJ_EN.
module o2_stim_gen #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned STAGGER  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    o2_stim_gen_if.slave bus
);

    localparam int unsigned      LAST    = (CHANNELS - 1) * STAGGER;
    localparam int unsigned      STG_W   = $clog2(LAST + 2);
    localparam logic [STG_W-1:0] STG_SAT = STG_W'(LAST + 1);

    typedef enum logic [1:0] {
        ModeFree    = 2'd0,
        ModeOneshot = 2'd1,
        ModeForce   = 2'd2,
        ModeRsvd    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StNormal,
        StLean,
        StRich
    } state_e;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CNT_W-1:0]    nlim_q  [CHANNELS];
    logic [CNT_W-1:0]    nlim_d  [CHANNELS];
    logic [CNT_W-1:0]    llim_q  [CHANNELS];
    logic [CNT_W-1:0]    llim_d  [CHANNELS];
    logic [CNT_W-1:0]    rlim_q  [CHANNELS];
    logic [CNT_W-1:0]    rlim_d  [CHANNELS];

    logic [STG_W-1:0]    stg_q, stg_d;
    logic                run_q, run_d;
    mode_e               mode_q, mode_n;
    logic [CHANNELS-1:0] top_q, top_d;
    logic [CHANNELS-1:0] bot_q, bot_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic                seq_q, seq_d;

    logic                forcing, abort, launch, active, all_idle;
    logic                enter_normal;
    state_e              force_st;

    // Shadow registers hold len-1 so a zero length degenerates to a 1-clock dwell.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    always_comb begin
        mode_n   = (bus.mode == ModeRsvd) ? ModeFree : mode_e'(bus.mode);
        forcing  = bus.en && (mode_n == ModeForce);
        abort    = !bus.en || (mode_n != mode_q);
        launch   = !forcing && !abort && !run_q &&
                   ((mode_n == ModeFree) || ((mode_n == ModeOneshot) && bus.start));
        active   = !forcing && !abort && (run_q || launch);
        case (bus.force_state)
            2'd1:    force_st = StLean;
            2'd2:    force_st = StRich;
            default: force_st = StNormal;
        endcase
    end

    always_comb begin
        done_d       = '0;
        top_d        = '0;
        bot_d        = '1;
        all_idle     = 1'b1;
        enter_normal = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            nlim_d[i]    = nlim_q[i];
            llim_d[i]    = llim_q[i];
            rlim_d[i]    = rlim_q[i];
            enter_normal = 1'b0;

            if (forcing) begin
                state_d[i] = force_st;
                cnt_d[i]   = '0;
            end else if (!active) begin
                state_d[i] = StIdle;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        // Saturated stagger count never matches, so channels launch once.
                        if (stg_q == STG_W'(i * STAGGER)) enter_normal = 1'b1;
                    end
                    StNormal: begin
                        if (cnt_q[i] == nlim_q[i]) begin
                            state_d[i] = StLean;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    StLean: begin
                        if (cnt_q[i] == llim_q[i]) begin
                            state_d[i] = StRich;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    StRich: begin
                        if (cnt_q[i] == rlim_q[i]) begin
                            done_d[i] = 1'b1;
                            if (mode_n == ModeOneshot) begin
                                state_d[i] = StIdle;
                                cnt_d[i]   = '0;
                            end else begin
                                enter_normal = 1'b1;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                endcase
            end

            if (enter_normal) begin
                state_d[i] = StNormal;
                cnt_d[i]   = '0;
                nlim_d[i]  = len_m1(bus.normal_len);
                llim_d[i]  = len_m1(bus.lean_len);
                rlim_d[i]  = len_m1(bus.rich_len);
            end

            if (state_d[i] != StIdle) all_idle = 1'b0;

            top_d[i] = (state_d[i] == StLean);
            bot_d[i] = (state_d[i] != StRich);
`ifdef O2_FAULT_INJ_EN
            if (bus.fault_mask[i]) begin
                top_d[i] = 1'b1;
                bot_d[i] = 1'b0;
            end
`endif
        end

        if (active) begin
            stg_d = (stg_q == STG_SAT) ? stg_q : stg_q + STG_W'(1);
        end else begin
            stg_d = '0;
        end

        // A one-shot ends once every channel has launched and all are back in IDLE.
        seq_d = active && (mode_n == ModeOneshot) && (stg_q == STG_SAT) && all_idle;
        run_d = active && !seq_d;
        if (seq_d) stg_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
                nlim_q[i]  <= '0;
                llim_q[i]  <= '0;
                rlim_q[i]  <= '0;
            end
            stg_q  <= '0;
            run_q  <= 1'b0;
            mode_q <= ModeFree;
            top_q  <= '0;
            bot_q  <= '1;
            done_q <= '0;
            seq_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                nlim_q[i]  <= nlim_d[i];
                llim_q[i]  <= llim_d[i];
                rlim_q[i]  <= rlim_d[i];
            end
            stg_q  <= stg_d;
            run_q  <= run_d;
            mode_q <= mode_n;
            top_q  <= top_d;
            bot_q  <= bot_d;
            done_q <= done_d;
            seq_q  <= seq_d;
        end
    end

    assign bus.o2_top     = top_q;
    assign bus.o2_bottom  = bot_q;
    assign bus.cycle_done = done_q;
    assign bus.seq_done   = seq_q;
    assign bus.busy       = run_q;

endmodule

// File: tb/tb_o2_stim_gen.sv
// Randomized self-checking bench for o2_stim_gen; the reference model expands each
// NORMAL entry into a queue of per-clock phases and replays it.
module tb_o2_stim_gen;

    localparam int unsigned CH  = 2;
    localparam int unsigned CW  = 24;
    localparam int          STG = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    o2_stim_gen_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

    o2_stim_gen #(
        .CHANNELS (CH),
        .CNT_W    (CW),
        .STAGGER  (STG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: phase 0=IDLE 1=NORMAL 2=LEAN 3=RICH; sched holds the phases still to come.
    int      phase [CH];
    int      sched [CH][$];
    bit      m_run;
    int      m_tick;
    int      m_prev;
    bit [CH-1:0] m_done;
    bit      m_seq;
`ifdef O2_FAULT_INJ_EN
    bit [CH-1:0] m_fault;
`endif

    int          n_tests;
    int          n_fail;
    int          first;
    int          seq_cnt;
    bit          found;
    int unsigned r;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input logic [CW-1:0] len);
        return (len == '0) ? 1 : int'(len);
    endfunction

    task automatic refill(input int i);
        sched[i].delete();
        for (int k = 0; k < eff_len(bus.normal_len); k++) sched[i].push_back(1);
        for (int k = 0; k < eff_len(bus.lean_len); k++)   sched[i].push_back(2);
        for (int k = 0; k < eff_len(bus.rich_len); k++)   sched[i].push_back(3);
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            phase[i] = 0;
            sched[i].delete();
        end
        m_run  = 1'b0;
        m_tick = 0;
        m_prev = 0;
        m_done = '0;
        m_seq  = 1'b0;
`ifdef O2_FAULT_INJ_EN
        m_fault = '0;
`endif
    endtask

    task automatic model_step();
        int nm;
        bit forcing, abort, all_idle;
        nm      = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
        forcing = bus.en && (nm == 2);
        abort   = !bus.en || (nm != m_prev);
        m_prev  = nm;
        m_done  = '0;
        m_seq   = 1'b0;
`ifdef O2_FAULT_INJ_EN
        m_fault = bus.fault_mask;
`endif
        if (forcing || abort) begin
            for (int i = 0; i < CH; i++) begin
                sched[i].delete();
                if (!forcing)                  phase[i] = 0;
                else if (bus.force_state == 1) phase[i] = 2;
                else if (bus.force_state == 2) phase[i] = 3;
                else                           phase[i] = 1;
            end
            m_run  = 1'b0;
            m_tick = 0;
        end else begin
            if (!m_run && (nm == 0 || (nm == 1 && bus.start))) begin
                m_run  = 1'b1;
                m_tick = 0;
            end
            if (m_run) begin
                for (int i = 0; i < CH; i++) begin
                    if (phase[i] != 0) begin
                        if (sched[i].size() > 0) begin
                            phase[i] = sched[i].pop_front();
                        end else begin
                            m_done[i] = 1'b1;
                            if (nm == 0) begin
                                refill(i);
                                phase[i] = sched[i].pop_front();
                            end else begin
                                phase[i] = 0;
                            end
                        end
                    end else if (m_tick == i * STG) begin
                        refill(i);
                        phase[i] = sched[i].pop_front();
                    end
                end
                m_tick++;
                all_idle = 1'b1;
                for (int i = 0; i < CH; i++) if (phase[i] != 0) all_idle = 1'b0;
                if (nm == 1 && m_tick > (CH - 1) * STG && all_idle) begin
                    m_seq = 1'b1;
                    m_run = 1'b0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [CH-1:0] et, eb;
        for (int i = 0; i < CH; i++) begin
            et[i] = (phase[i] == 2);
            eb[i] = (phase[i] != 3);
`ifdef O2_FAULT_INJ_EN
            if (m_fault[i]) begin
                et[i] = 1'b1;
                eb[i] = 1'b0;
            end
`endif
        end
        check_eq("o2_top", 32'(bus.o2_top), 32'(et));
        check_eq("o2_bottom", 32'(bus.o2_bottom), 32'(eb));
        check_eq("cycle_done", 32'(bus.cycle_done), 32'(m_done));
        check_eq("seq_done", 32'(bus.seq_done), 32'(m_seq));
        check_eq("busy", 32'(bus.busy), 32'(m_run));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        compare();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        bus.en          = 1'b0;
        bus.mode        = 2'd0;
        bus.start       = 1'b0;
        bus.force_state = 2'd0;
        bus.normal_len  = CW'(3);
        bus.lean_len    = CW'(2);
        bus.rich_len    = CW'(5);
`ifdef O2_FAULT_INJ_EN
        bus.fault_mask  = '0;
`endif
        model_reset();

        // Reset, then idle with en=0.
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check_eq("idle_top", 32'(bus.o2_top), 32'd0);
        check_eq("idle_bottom", 32'(bus.o2_bottom), 32'd3);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);

        // FREE 3/2/5: first ch0 cycle_done ten clocks after launch.
        bus.en = 1'b1;
        first  = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (first < 0 && bus.cycle_done[0]) first = k;
        end
        check_eq("free_first_done", 32'(first), 32'd10);

        // ONESHOT 1/1/1 with a second start while busy.
        bus.en = 1'b0;
        tick();
        bus.en         = 1'b1;
        bus.mode       = 2'd1;
        bus.normal_len = CW'(1);
        bus.lean_len   = CW'(1);
        bus.rich_len   = CW'(1);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        seq_cnt   = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (bus.seq_done) seq_cnt++;
        end
        check_eq("oneshot_seq_cnt", 32'(seq_cnt), 32'd1);
        check_eq("oneshot_busy_end", 32'(bus.busy), 32'd0);

        // FORCE RICH, then back to FREE.
        bus.mode        = 2'd2;
        bus.force_state = 2'd2;
        tick();
        check_eq("force_top", 32'(bus.o2_top), 32'd0);
        check_eq("force_bottom", 32'(bus.o2_bottom), 32'd0);
        repeat (3) tick();
        bus.mode = 2'd0;
        tick();
        check_eq("unforce_bottom", 32'(bus.o2_bottom), 32'd3);
        repeat (20) tick();

        // Zero lengths: one clock per phase.
        bus.en = 1'b0;
        tick();
        bus.en         = 1'b1;
        bus.normal_len = '0;
        bus.lean_len   = '0;
        bus.rich_len   = '0;
        repeat (20) tick();

        // normal_len 3 -> 6 changed while ch0 is in LEAN.
        bus.en = 1'b0;
        tick();
        bus.en         = 1'b1;
        bus.normal_len = CW'(3);
        bus.lean_len   = CW'(2);
        bus.rich_len   = CW'(5);
        found          = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!found) begin
                tick();
                if (phase[0] == 2) found = 1'b1;
            end
        end
        check_eq("wait_lean", 32'(found), 32'd1);
        bus.normal_len = CW'(6);
        repeat (40) tick();

        // Asynchronous reset while ch0 is in RICH.
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!found) begin
                tick();
                if (phase[0] == 3) found = 1'b1;
            end
        end
        check_eq("wait_rich", 32'(found), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("arst_top", 32'(bus.o2_top), 32'd0);
        check_eq("arst_bottom", 32'(bus.o2_bottom), 32'd3);
        check_eq("arst_busy", 32'(bus.busy), 32'd0);
        check_eq("arst_done", 32'(bus.cycle_done), 32'd0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (15) tick();

`ifdef O2_FAULT_INJ_EN
        bus.fault_mask = 2'b01;
        tick();
        check_eq("fault_top0", 32'(bus.o2_top[0]), 32'd1);
        check_eq("fault_bottom0", 32'(bus.o2_bottom[0]), 32'd0);
        repeat (12) tick();
        bus.fault_mask = '0;
        repeat (5) tick();
`endif

        // Randomized control traffic.
        for (int k = 0; k < 900; k++) begin
            r         = $urandom_range(0, 99);
            bus.start = 1'b0;
            if (r < 2)        bus.en = 1'b0;
            else if (r < 8)   bus.en = 1'b1;
            else if (r < 11)  bus.mode = 2'($urandom_range(0, 3));
            else if (r < 14)  bus.force_state = 2'($urandom_range(0, 3));
            else if (r < 18)  bus.normal_len = CW'($urandom_range(0, 6));
            else if (r < 22)  bus.lean_len = CW'($urandom_range(0, 6));
            else if (r < 26)  bus.rich_len = CW'($urandom_range(0, 6));
            else if (r < 40)  bus.start = 1'b1;
`ifdef O2_FAULT_INJ_EN
            else if (r < 43)  bus.fault_mask = CH'($urandom_range(0, 3));
`endif
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
